// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding select encodings and divider FSM state.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divider interlock: holds E for DIV_CYCLES cycles,
// then releases the divide in DONE once the data cache is quiet.
module div_stall_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_startE,
  input  logic d_cache_stall,
  input  logic abort,
  output logic div_stall,
  output logic div_busy
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && div_startE
                  && !d_cache_stall && !abort;

  // The accept cycle itself is the first stalled cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= CNT_W'(DIV_CYCLES - 2);
          end
        end
        RUN: begin
          if (r_cnt == '0) r_state <= DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        DONE: begin
          if (!d_cache_stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_stall = w_accept || (r_state == RUN);
  assign div_busy  = (r_state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, interlocks,
// divider stall and precise exception flush for the 5-stage core.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_cache_stall,
  input  logic              d_cache_stall,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic              branchD,
  input  logic              reg_write_enE,
  input  logic              reg_write_enM,
  input  logic              reg_write_enW,
  input  logic [REG_AW-1:0] reg_writeE,
  input  logic [REG_AW-1:0] reg_writeM,
  input  logic [REG_AW-1:0] reg_writeW,
  input  logic              mem_read_enE,
  input  logic              mem_read_enM,
  input  logic              div_startE,
  input  logic              flush_excM,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic [1:0]        forward_aE,
  output logic [1:0]        forward_bE,
  output logic              forward_aD,
  output logic              forward_bD,
  output logic              div_busy
);

  function automatic logic hit(
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [REG_AW-1:0] src
  );
    if (reg_write_enM && hit(src, reg_writeM)) return FWD_MEM;
    if (reg_write_enW && hit(src, reg_writeW)) return FWD_WB;
    return FWD_NONE;
  endfunction

  logic       r_pend_exc;
  logic       w_exc;
  logic       w_lu;
  logic       w_div_stall;
  logic       w_e_hit;
  logic       w_m_hit;
  logic [4:0] w_st;
  logic [3:0] w_fl;

  assign forward_aE = fwd_e(rsE);
  assign forward_bE = fwd_e(rtE);
  assign forward_aD = reg_write_enM && !mem_read_enM
                    && hit(rsD, reg_writeM);
  assign forward_bD = reg_write_enM && !mem_read_enM
                    && hit(rtD, reg_writeM);

  assign w_e_hit = hit(rsD, reg_writeE) || hit(rtD, reg_writeE);
  assign w_m_hit = hit(rsD, reg_writeM) || hit(rtD, reg_writeM);
  assign w_lu    = (mem_read_enE && w_e_hit)
                 || (branchD && ((reg_write_enE && w_e_hit)
                              || (mem_read_enM && w_m_hit)));

  // An exception seen under a D-cache stall is held until it drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            r_pend_exc <= 1'b0;
    else if (d_cache_stall) r_pend_exc <= r_pend_exc | flush_excM;
    else                    r_pend_exc <= 1'b0;
  end

  assign w_exc = (flush_excM || r_pend_exc) && !d_cache_stall;

  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_div (
    .clk          (clk),
    .resetn       (resetn),
    .div_startE   (div_startE),
    .d_cache_stall(d_cache_stall),
    .abort        (w_exc),
    .div_stall    (w_div_stall),
    .div_busy     (div_busy)
  );

  always_comb begin
    w_st = '0;
    w_fl = '0;
    if (resetn) begin
      if (d_cache_stall) begin
        w_st = 5'b11111;
      end else if (w_exc) begin
        w_fl = 4'b1111;
      end else if (w_div_stall) begin
        w_st = 5'b11100;
        w_fl = 4'b0001;
      end else if (w_lu) begin
        w_st = 5'b11000;
        w_fl = 4'b0010;
      end else if (i_cache_stall) begin
        w_st = 5'b10000;
        w_fl = 4'b0100;
      end
    end
  end

  assign {stallF, stallD, stallE, stallM, stallW} = w_st;
  assign {flushF, flushD, flushE, flushM}         = w_fl;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random stimulus
// compared against a cycle-age reference model.
module tb_hazard_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       i_cache_stall, d_cache_stall;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       branchD;
  logic       reg_write_enE, reg_write_enM, reg_write_enW;
  logic [4:0] reg_writeE, reg_writeM, reg_writeW;
  logic       mem_read_enE, mem_read_enM;
  logic       div_startE, flush_excM;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushF, flushD, flushE, flushM;
  logic [1:0] forward_aE, forward_bE;
  logic       forward_aD, forward_bD, div_busy;

  int errs = 0;
  int checks = 0;

  // Model: age = cycles since divide accept (0 = none in flight).
  int   m_age;
  logic m_pend;

  hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(N)) dut (
    .clk(clk), .resetn(resetn),
    .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .branchD(branchD),
    .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
    .reg_write_enW(reg_write_enW),
    .reg_writeE(reg_writeE), .reg_writeM(reg_writeM),
    .reg_writeW(reg_writeW),
    .mem_read_enE(mem_read_enE), .mem_read_enM(mem_read_enM),
    .div_startE(div_startE), .flush_excM(flush_excM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM),
    .forward_aE(forward_aE), .forward_bE(forward_bE),
    .forward_aD(forward_aD), .forward_bD(forward_bD),
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  wire [15:0] dut_v = {stallF, stallD, stallE, stallM, stallW,
                       flushF, flushD, flushE, flushM,
                       forward_aE, forward_bE,
                       forward_aD, forward_bD, div_busy};

  wire m_exc = (flush_excM | m_pend) & ~d_cache_stall;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_age  <= 0;
      m_pend <= 1'b0;
    end else begin
      m_pend <= d_cache_stall ? (m_pend | flush_excM) : 1'b0;
      if (m_exc)           m_age <= 0;
      else if (m_age == 0) m_age <= (div_startE && !d_cache_stall) ? 1 : 0;
      else if (m_age < N)  m_age <= m_age + 1;
      else                 m_age <= d_cache_stall ? N : 0;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(logic [4:0] a, logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] mfwd(logic [4:0] s);
    if (reg_write_enM && hit(s, reg_writeM)) return 2'b01;
    if (reg_write_enW && hit(s, reg_writeW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] model();
    logic [4:0] st;
    logic [3:0] fl;
    logic hold, lu, ed, md, busy, faD, fbD;
    st   = '0;
    fl   = '0;
    hold = (m_age >= 1 && m_age <= N - 1)
        || (m_age == 0 && div_startE && !d_cache_stall && !m_exc);
    ed   = hit(rsD, reg_writeE) || hit(rtD, reg_writeE);
    md   = hit(rsD, reg_writeM) || hit(rtD, reg_writeM);
    lu   = (mem_read_enE && ed)
        || (branchD && ((reg_write_enE && ed) || (mem_read_enM && md)));
    busy = (m_age != 0);
    if (d_cache_stall)      st = 5'b11111;
    else if (m_exc)         fl = 4'b1111;
    else if (hold)          begin st = 5'b11100; fl = 4'b0001; end
    else if (lu)            begin st = 5'b11000; fl = 4'b0010; end
    else if (i_cache_stall) begin st = 5'b10000; fl = 4'b0100; end
    if (!resetn) begin
      st = '0; fl = '0; busy = 1'b0;
    end
    faD = reg_write_enM && !mem_read_enM && hit(rsD, reg_writeM);
    fbD = reg_write_enM && !mem_read_enM && hit(rtD, reg_writeM);
    return {st, fl, mfwd(rsE), mfwd(rtE), faD, fbD, busy};
  endfunction

  task automatic clr();
    {i_cache_stall, d_cache_stall, branchD, div_startE, flush_excM} = '0;
    {reg_write_enE, reg_write_enM, reg_write_enW} = '0;
    {mem_read_enE, mem_read_enM} = '0;
    {rsD, rtD, rsE, rtE} = '0;
    {reg_writeE, reg_writeM, reg_writeW} = '0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr();
  endtask

  task automatic mchk(string tag);
    chk(tag, dut_v, model());
  endtask

  initial begin
    clr();
    #1;
    chk("reset_zero", dut_v, 16'h0);
    rsE = 8; reg_write_enM = 1; reg_writeM = 8;
    #1;
    chk("reset_fwd", forward_aE, 2'b01);
    chk("reset_nostall", {stallF, flushM, div_busy}, 3'b000);

    nxt(); resetn = 1'b1;
    reg_write_enM = 1; reg_writeM = 8; rsE = 8;
    reg_write_enW = 1; reg_writeW = 8;
    #1;
    chk("fwd_m_over_w", forward_aE, 2'b01);
    mchk("fwd_m_over_w_all");

    nxt(); reg_write_enW = 1; reg_writeW = 8; rsE = 8; rtE = 8;
    #1;
    chk("fwd_w", {forward_aE, forward_bE}, 4'b1010);

    nxt(); reg_write_enM = 1; reg_write_enW = 1;
    #1;
    chk("fwd_r0", forward_aE, 2'b00);

    nxt(); mem_read_enE = 1; reg_write_enE = 1; reg_writeE = 9; rtD = 9;
    #1;
    chk("lu_stall", {stallF, stallD, stallE, flushE}, 4'b1101);
    mchk("lu_all");
    nxt(); mem_read_enM = 1; reg_write_enM = 1; reg_writeM = 9; rtE = 9;
    #1;
    chk("lu_fwd", forward_bE, 2'b01);
    chk("lu_release", stallF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      nxt(); div_startE = (i <= 4);
      #1;
      chk($sformatf("div_stallE%0d", i), stallE, (i < 4));
      chk($sformatf("div_flushM%0d", i), flushM, (i < 4));
      chk($sformatf("div_busy%0d", i), div_busy, (i >= 1 && i <= 4));
    end

    for (int i = 0; i < 6; i++) begin
      nxt(); div_startE = (i <= 4); d_cache_stall = (i == 1 || i == 2);
      #1;
      chk($sformatf("divdc_stallE%0d", i), stallE, (i < 4));
      chk($sformatf("divdc_flushM%0d", i), flushM, (i == 0 || i == 3));
      chk($sformatf("divdc_busy%0d", i), div_busy, (i >= 1 && i <= 4));
    end

    for (int i = 0; i < 5; i++) begin
      nxt(); d_cache_stall = (i < 3); flush_excM = (i == 0);
      #1;
      chk($sformatf("exc_flush%0d", i),
          {flushF, flushD, flushE, flushM}, (i == 3) ? 4'hF : 4'h0);
      chk($sformatf("exc_stallF%0d", i), stallF, (i < 3));
    end

    nxt(); div_startE = 1;
    nxt(); div_startE = 1;
    #1;
    chk("rst_pre_busy", div_busy, 1'b1);
    nxt(); div_startE = 1; resetn = 1'b0;
    #1;
    chk("rst_mid_div", dut_v, 16'h0);
    for (int i = 0; i < 5; i++) begin
      nxt(); resetn = 1'b1; div_startE = (i <= 4);
      #1;
      chk($sformatf("rst_restart%0d", i), stallE, (i < 4));
    end

    for (int i = 0; i < 400; i++) begin
      nxt();
      resetn        = ($urandom_range(0, 99) != 0);
      i_cache_stall = ($urandom_range(0, 3) == 0);
      d_cache_stall = ($urandom_range(0, 3) == 0);
      branchD       = $urandom_range(0, 1);
      div_startE    = $urandom_range(0, 1);
      flush_excM    = ($urandom_range(0, 9) == 0);
      reg_write_enE = $urandom_range(0, 1);
      reg_write_enM = $urandom_range(0, 1);
      reg_write_enW = $urandom_range(0, 1);
      mem_read_enE  = $urandom_range(0, 1);
      mem_read_enM  = $urandom_range(0, 1);
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      reg_writeE = 5'($urandom_range(0, 3));
      reg_writeM = 5'($urandom_range(0, 3));
      reg_writeW = 5'($urandom_range(0, 3));
      #1;
      mchk($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage core. It produces per-stage stall and flush controls, plus forwarding selects for the E-stage ALU operands and the D-stage branch comparator. It supersedes the combinational cache-stall/forwarding unit and adds:
- load-use and branch-use interlocks,
- a sequential multi-cycle divider interlock,
- a precise-exception flush that survives a concurrent data-cache stall,
- `$0` suppression.

## Interface
Parameters:
- `REG_AW`, 5, register address width.
- `DIV_CYCLES`, 32, number of cycles E is held for a divide; must be ≥ 2.
- `CNT_W`, `$clog2(DIV_CYCLES)`, divider counter width (derived).

Ports:
- `clk`  in  1  core clock.
- `resetn`  in  1  asynchronous active-low reset.
- `i_cache_stall`, `d_cache_stall`  in  1  cache miss stalls.
- `rsD`, `rtD`, `rsE`, `rtE`  in  `REG_AW`  source registers.
- `branchD`  in  1  D holds a branch/jump-register needing its operands.
- `reg_write_enE`, `reg_write_enM`, `reg_write_enW`  in  1  write enables.
- `reg_writeE`, `reg_writeM`, `reg_writeW`  in  `REG_AW`  destination registers.
- `mem_read_enE`, `mem_read_enM`  in  1  load in that stage.
- `div_startE`  in  1  E holds a div/divu.
- `flush_excM`  in  1  exception committed in M (single-cycle pulse).
- `stallF`, `stallD`, `stallE`, `stallM`, `stallW`  out  1  hold pipeline register.
- `flushF`, `flushD`, `flushE`, `flushM`  out  1  bubble pipeline register.
- `forward_aE`, `forward_bE`  out  2  00 none, 01 M, 10 W.
- `forward_aD`, `forward_bD`  out  1  forward ALU result from M.
- `div_busy`  out  1  divider FSM not IDLE.

## Operation
- Any match against register 0 is ignored for forwarding and interlocks.
- E forwarding priority: M over W; a match requires the corresponding write enable.
- D forwarding: select M when `reg_write_enM`, M is not a load, and the destination matches.
- Interlock `lu`: either of
  - `mem_read_enE` with `reg_writeE` in {`rsD`, `rtD`};
  - `branchD` with either of
    - (`reg_write_enE` and `reg_writeE` matching), or
    - (`mem_read_enM` and `reg_writeM` matching).
- Divider FSM states:
  - IDLE: `div_startE` & !`d_cache_stall` & no exception → RUN, with `cnt` = `DIV_CYCLES`−2.
  - RUN: `cnt` decrements each cycle, including during cache stalls; at `cnt`==0 → DONE.
  - DONE: `div_startE` is ignored; → IDLE on the first cycle with !`d_cache_stall`.
- `div_stall` = (IDLE & `div_startE` & accepted) | RUN.
- Exception flush:
  - `pend_exc` is set when `flush_excM` arrives while `d_cache_stall`=1.
  - `pend_exc` clears on the first cycle with `d_cache_stall`=0.
  - `exc` = (`flush_excM` | `pend_exc`) & !`d_cache_stall`.
  - Any `exc` forces the divider FSM to IDLE.
- Output priority, highest first:
  1. `d_cache_stall`: all stalls = 1, all flushes = 0.
  2. `exc`: `flushF`/`D`/`E`/`M` = 1, all stalls = 0.
  3. `div_stall`: `stallF`/`D`/`E` = 1, `flushM` = 1.
  4. `lu`: `stallF`/`D` = 1, `flushE` = 1.
  5. `i_cache_stall`: `stallF` = 1, `flushD` = 1.
  6. Otherwise all stalls and flushes = 0.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and registered state, valid in the same cycle.
- The only registered state is the FSM, `cnt` and `pend_exc`.
- While `resetn`=0:
  - FSM = IDLE, `cnt` = 0, `pend_exc` = 0;
  - every stall, flush and `div_busy` output = 0;
  - forwards still decode.
- Divide:
  - E is stalled for exactly `DIV_CYCLES` consecutive cycles, counting from the accept cycle, when no cache stall occurs.
  - The div instruction advances in the DONE cycle.
- A `d_cache_stall` overlapping RUN does not extend the count.
- A `d_cache_stall` overlapping DONE holds the FSM in DONE.
- `div_busy` = 1 in RUN and DONE.
- Simultaneous `flush_excM` and `lu`/`div_stall`: exception wins; the interlocked instructions are flushed.
- A reset mid-divide returns the FSM to IDLE immediately (asynchronous).

## Structure
- Package `pipe_ctrl_pkg`:
  - `FWD_NONE`/`FWD_MEM`/`FWD_WB` constants;
  - `div_state_t` enum {IDLE, RUN, DONE}.
- Sub-module `div_stall_fsm`:
  - inputs: `clk`, `resetn`, `div_startE`, `d_cache_stall`, `abort`;
  - outputs: `div_stall`, `div_busy`.
- The top level contains the forwarding decode, the interlock logic, `pend_exc` and the priority mux.

## Test plan
- `reg_write_enM`=1, `reg_writeM`=8, `rsE`=8, `reg_write_enW`=1, `reg_writeW`=8 → `forward_aE`=01.
- Same stimulus with register 0 (all matching addresses 0) → `forward_aE`=00.
- Load-use: `mem_read_enE`=1, `reg_writeE`=9, `rtD`=9 → one cycle of `stallF`=`stallD`=`flushE`=1; next cycle with the load in M → `forward_bE`=01 and no stall.
- Divide with `DIV_CYCLES`=4: `div_startE` held high → `stallE`=1 for exactly 4 cycles with `flushM`=1, then released; `div_busy` high for 4 cycles. Inject `d_cache_stall` for 2 cycles in RUN → still exactly 4 divider-owned cycles.
- `flush_excM` while `d_cache_stall`=1 for 3 cycles → no flush during the stall; `flushF..M`=1 for one cycle when the stall drops; `pend_exc` then cleared.
- Assert `resetn`=0 in RUN → all outputs 0 and `div_busy`=0 immediately; after release, `div_startE`=1 restarts the full `DIV_CYCLES` stall.
